// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// uart_rx: serial receiver for idle-high frames of one start bit (0),
// D_WIDTH data bits LSB first, and one stop bit (1). Each bit lasts
// CLKS_PER_BIT clocks. Recovered words are held in a single-entry
// valid/ready output register. Framing errors and overruns are pulsed.
module uart_rx #(
    parameter int D_WIDTH      = 15,
    parameter int CLKS_PER_BIT = 1,
    parameter int SYNC_STAGES  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx,
    output logic [D_WIDTH-1:0] rx_data,
    output logic               rx_valid,
    input  logic               rx_ready,
    output logic               rx_busy,
    output logic               rx_frame_err,
    output logic               rx_overrun
);

    localparam int HALF = (CLKS_PER_BIT - 1) / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT) + 1;
    localparam int BW   = $clog2(D_WIDTH) + 1;

    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_CNT = CW'(HALF);
    localparam logic [BW-1:0] LAST_BIT = BW'(D_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [BW-1:0]      bitcnt;
    logic [D_WIDTH-1:0] shreg;
    logic               rx_s;
    logic               sample_data;
    logic               xfer;

    // Input synchroniser; SYNC_STAGES==0 feeds rx straight to the FSM.
    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign rx_s = rx;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync;

            // Shift rx through the synchroniser chain; reset to the idle level.
            // NOTE: sequential state uses <= so every flop samples pre-edge values.
            always_ff @(posedge clk) begin
                if (rst) begin
                    sync <= '1;
                end else begin
                    sync[0] <= rx;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sync[i] <= sync[i-1];
                    end
                end
            end

            assign rx_s = sync[SYNC_STAGES-1];
        end
    endgenerate

    assign sample_data = (state == DATA) && (cnt == LAST_CNT);
    assign xfer        = rx_valid && rx_ready;

    // Shift data samples in at the MSB so the first bit lands at the LSB.
    // NOTE: no reset on this datapath register; a full frame overwrites it before any commit.
    always_ff @(posedge clk) begin
        if (sample_data) begin
            shreg <= {rx_s, shreg[D_WIDTH-1:1]};
        end
    end

    // Receive FSM, output register and error pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            bitcnt       <= '0;
            rx_busy      <= 1'b0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
        end else begin
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
            // NOTE: a commit later in this block overrides this clear (last <= wins).
            if (xfer) begin
                rx_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        rx_busy <= 1'b1;
                        bitcnt  <= '0;
                        if (HALF == 0) begin
                            state <= DATA;
                            cnt   <= '0;
                        end else begin
                            state <= START;
                            cnt   <= CW'(1);
                        end
                    end
                end

                START: begin
                    if (cnt == HALF_CNT) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state <= DATA;
                        end else begin
                            state   <= IDLE;
                            rx_busy <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (cnt == LAST_CNT) begin
                        cnt <= '0;
                        if (bitcnt == LAST_BIT) begin
                            state <= STOP;
                        end else begin
                            bitcnt <= bitcnt + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (cnt == LAST_CNT) begin
                        cnt <= '0;
                        if (rx_s) begin
                            state   <= IDLE;
                            rx_busy <= 1'b0;
                            if (!rx_valid || xfer) begin
                                rx_data  <= shreg;
                                rx_valid <= 1'b1;
                            end else begin
                                rx_overrun <= 1'b1;
                            end
                        end else begin
                            state        <= BREAK;
                            rx_frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                BREAK: begin
                    if (rx_s) begin
                        state   <= IDLE;
                        rx_busy <= 1'b0;
                    end
                end

                default: begin
                    state   <= IDLE;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
// tb_uart_rx: scoreboard bench. Instance 0 uses default parameters and
// instance 1 uses CLKS_PER_BIT=4. Frame drivers push expected words and
// error events, derived from frame-level rules. A negedge monitor pops
// and compares them whenever the DUTs present an output.
module tb_uart_rx;

    localparam int D    = 15;
    localparam int SYNC = 2;
    localparam int CPB0 = 1;
    localparam int CPB1 = 4;
    localparam int LAT0 = SYNC + (CPB0 - 1) / 2 + (D + 1) * CPB0 + 1;
    localparam int LAT1 = SYNC + (CPB1 - 1) / 2 + (D + 1) * CPB1 + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst0, rst1, rx0, rx1, rdy0, rdy1;
    logic [D-1:0] data0, data1;
    logic         v0, v1, busy0, busy1, fe0, fe1, ov0, ov1;

    uart_rx #(.D_WIDTH(D), .CLKS_PER_BIT(CPB0), .SYNC_STAGES(SYNC)) dut0 (
        .clk(clk), .rst(rst0), .rx(rx0), .rx_data(data0), .rx_valid(v0),
        .rx_ready(rdy0), .rx_busy(busy0), .rx_frame_err(fe0), .rx_overrun(ov0)
    );

    uart_rx #(.D_WIDTH(D), .CLKS_PER_BIT(CPB1), .SYNC_STAGES(SYNC)) dut1 (
        .clk(clk), .rst(rst1), .rx(rx1), .rx_data(data1), .rx_valid(v1),
        .rx_ready(rdy1), .rx_busy(busy1), .rx_frame_err(fe1), .rx_overrun(ov1)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int           inst;
        logic [D-1:0] data;
        int           cyc;
    } word_t;

    typedef struct {
        int inst;
        int cyc;
    } ev_t;

    word_t exp_q[$];
    ev_t   ferr_q[$];
    ev_t   ovr_q[$];
    bit    held[2];

    // Frame-level reference: a bad stop bit gives a frame error; a good frame
    // either fills the output slot or, if the slot is full and the consumer
    // is not accepting, is lost with an overrun. Events land k+latency.
    task automatic model_frame(input int inst, input logic [D-1:0] w, input logic stop_ok, input int k);
        int   lat = (inst == 0) ? LAT0 : LAT1;
        logic r   = (inst == 0) ? rdy0 : rdy1;
        if (!stop_ok) begin
            ferr_q.push_back('{inst, k + lat});
        end else if (held[inst] && !r) begin
            ovr_q.push_back('{inst, k + lat});
        end else begin
            exp_q.push_back('{inst, w, k + lat});
            held[inst] = !r;
        end
    endtask

    // Monitor: stability while stalled, word transfers, error pulses.
    logic         pv[2]   = '{1'b0, 1'b0};
    logic         px[2]   = '{1'b0, 1'b0};
    logic         pr[2]   = '{1'b0, 1'b0};
    logic         prst[2] = '{1'b1, 1'b1};
    logic [D-1:0] pd[2];
    int           appear[2];
    logic         m_v, m_r, m_fe, m_ov, m_rs;
    logic [D-1:0] m_d;
    word_t        m_w;
    ev_t          m_e;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            m_v  = (i == 0) ? v0    : v1;
            m_r  = (i == 0) ? rdy0  : rdy1;
            m_fe = (i == 0) ? fe0   : fe1;
            m_ov = (i == 0) ? ov0   : ov1;
            m_rs = (i == 0) ? rst0  : rst1;
            m_d  = (i == 0) ? data0 : data1;

            if (pv[i] && !pr[i] && !prst[i]) begin
                check("stall_valid", m_v, 1'b1);
                check("stall_data", m_d, pd[i]);
            end
            if (m_v && (!pv[i] || px[i])) appear[i] = cyc;

            if (m_v === 1'b1 && m_r === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", m_d, 64'hDEAD);
                end else begin
                    m_w = exp_q.pop_front();
                    check("word_inst", i, m_w.inst);
                    check("word_data", m_d, m_w.data);
                    check("word_cycle", appear[i], m_w.cyc);
                end
            end
            if (m_fe === 1'b1) begin
                if (ferr_q.size() == 0) begin
                    check("unexpected_frame_err", 1, 0);
                end else begin
                    m_e = ferr_q.pop_front();
                    check("ferr_inst", i, m_e.inst);
                    check("ferr_cycle", cyc, m_e.cyc);
                end
            end
            if (m_ov === 1'b1) begin
                if (ovr_q.size() == 0) begin
                    check("unexpected_overrun", 1, 0);
                end else begin
                    m_e = ovr_q.pop_front();
                    check("ovr_inst", i, m_e.inst);
                    check("ovr_cycle", cyc, m_e.cyc);
                end
            end
            if (m_fe === 1'b1 && m_ov === 1'b1) check("ferr_and_overrun", 1, 0);

            pv[i]   = m_v;
            px[i]   = m_v && m_r;
            pr[i]   = m_r;
            prst[i] = m_rs;
            pd[i]   = m_d;
        end
    end

    task automatic drive(input int inst, input logic b);
        @(posedge clk);
        #1;
        if (inst == 0) rx0 = b;
        else           rx1 = b;
    endtask

    task automatic idle(input int inst, input int n);
        repeat (n) drive(inst, 1'b1);
    endtask

    task automatic send_frame(input int inst, input logic [D-1:0] w, input logic stop_bit, output int k);
        int           cpb  = (inst == 0) ? CPB0 : CPB1;
        logic [D+1:0] bits = {stop_bit, w, 1'b0};
        k = 0;
        for (int b = 0; b < D + 2; b++) begin
            for (int c = 0; c < cpb; c++) begin
                drive(inst, bits[b]);
                if (b == 0 && c == 0) begin
                    k = cyc;
                    model_frame(inst, w, stop_bit, k);
                end
            end
        end
    endtask

    task automatic at_cycle(input int t);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (cyc < t && n < 2000);
        if (cyc != t) check("at_cycle", cyc, t);
    endtask

    task automatic wait_drain(input int max);
        int n = 0;
        while ((exp_q.size() + ferr_q.size() + ovr_q.size()) != 0 && n < max) begin
            @(posedge clk);
            n++;
        end
        check("drain_pending", exp_q.size() + ferr_q.size() + ovr_q.size(), 0);
    endtask

    initial begin
        int           k, k2, r;
        logic [D-1:0] w;
        logic [D+1:0] bits;

        rst0 = 1'b1; rst1 = 1'b1;
        rx0  = 1'b1; rx1  = 1'b1;
        rdy0 = 1'b1; rdy1 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst0 = 1'b0; rst1 = 1'b0;
        @(negedge clk);
        check("rst_valid0", v0, 1'b0);
        check("rst_data0", data0, '0);
        check("rst_busy0", busy0, 1'b0);
        check("rst_ferr0", fe0, 1'b0);
        check("rst_ovr0", ov0, 1'b0);
        check("rst_valid1", v1, 1'b0);
        check("rst_data1", data1, '0);
        check("rst_busy1", busy1, 1'b0);

        // Basic frame: single-cycle valid at k+19.
        idle(0, 2);
        send_frame(0, 15'h5A3C, 1'b1, k);
        at_cycle(k + LAT0 + 1);
        check("basic_valid_one_cycle", v0, 1'b0);
        wait_drain(50);

        // Back-to-back frames with no gap.
        send_frame(0, 15'h0001, 1'b1, k);
        send_frame(0, 15'h7FFF, 1'b1, k);
        send_frame(0, 15'h2AAA, 1'b1, k);
        wait_drain(60);
        idle(0, 3);

        // Overrun: consumer stalled across two frames.
        @(posedge clk); #1; rdy0 = 1'b0;
        send_frame(0, 15'h1234, 1'b1, k);
        send_frame(0, 15'h4321, 1'b1, k2);
        at_cycle(k2 + LAT0 + 3);
        check("ovr_held_valid", v0, 1'b1);
        check("ovr_held_data", data0, 15'h1234);
        check("ovr_pending", ovr_q.size(), 0);
        @(posedge clk); #1; rdy0 = 1'b1; held[0] = 1'b0;
        @(posedge clk); #1;
        check("ovr_valid_drops", v0, 1'b0);
        wait_drain(20);

        // Framing error followed by a held break.
        idle(0, 2);
        send_frame(0, 15'h00FF, 1'b0, k);
        repeat (20) drive(0, 1'b0);
        check("break_busy_mid", busy0, 1'b1);
        repeat (20) drive(0, 1'b0);
        check("break_no_valid", v0, 1'b0);
        drive(0, 1'b1);
        r = cyc;
        at_cycle(r + SYNC);
        check("break_busy_until_idle", busy0, 1'b1);
        at_cycle(r + SYNC + 1);
        check("break_busy_released", busy0, 1'b0);
        idle(0, 2);
        send_frame(0, 15'h0F0F, 1'b1, k);
        wait_drain(40);

        // Reset after 8 data bits; remaining bits are ones so nothing restarts.
        idle(0, 3);
        w    = {7'h7F, 8'($urandom)};
        bits = {1'b1, w, 1'b0};
        for (int b = 0; b < D + 2; b++) begin
            drive(0, bits[b]);
            if (b == 0) k = cyc;
            if (b == 9) begin
                rst0 = 1'b1;
                @(negedge clk);
                check("busy_before_reset", busy0, 1'b1);
            end
            if (b == 10) begin
                rst0 = 1'b0;
                @(negedge clk);
                check("reset_busy_clear", busy0, 1'b0);
                check("reset_valid_clear", v0, 1'b0);
            end
        end
        idle(0, 25);
        send_frame(0, 15'($urandom), 1'b1, k);
        wait_drain(40);

        // Random words with random gaps, consumer always ready.
        for (int n = 0; n < 8; n++) begin
            idle(0, $urandom_range(0, 3));
            send_frame(0, 15'($urandom), 1'b1, k);
        end
        wait_drain(60);

        // Glitch rejection on the 4-clock-per-bit receiver.
        idle(1, 2);
        drive(1, 1'b0);
        k = cyc;
        drive(1, 1'b1);
        at_cycle(k + SYNC + 1);
        check("glitch_busy_start", busy1, 1'b1);
        at_cycle(k + SYNC + 2);
        check("glitch_busy_idle", busy1, 1'b0);
        idle(1, 10);
        send_frame(1, 15'h3C3C, 1'b1, k);
        for (int n = 0; n < 2; n++) begin
            idle(1, $urandom_range(0, 5));
            send_frame(1, 15'($urandom), 1'b1, k);
        end
        wait_drain(200);

        repeat (10) @(posedge clk);
        check("final_queues_empty", exp_q.size() + ferr_q.size() + ovr_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
